// File: rtl/baud_gen.sv
// UART bit-rate strobe generator: divides clk down to a one-cycle baud_tick per bit
// period and an independent os_tick at OVERSAMPLE times that rate.
module baud_gen #(
    parameter int CLK_FREQ   = 25_000_000,
    parameter int BAUD_RATE  = 115200,
    parameter int OVERSAMPLE = 16
) (
    input  logic clk,
    input  logic rst,
    output logic baud_tick,
    output logic os_tick
);

    localparam int OS_RATE    = BAUD_RATE * OVERSAMPLE;
    localparam int DIV_RAW    = (CLK_FREQ + BAUD_RATE / 2) / BAUD_RATE;
    localparam int OS_DIV_RAW = (CLK_FREQ + OS_RATE / 2) / OS_RATE;
    localparam int DIV        = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int OS_DIV     = (OS_DIV_RAW < 1) ? 1 : OS_DIV_RAW;

    // A divide-by-1 still needs a 1-bit counter; it simply stays at 0.
    localparam int BW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int OW  = (OS_DIV > 1) ? $clog2(OS_DIV) : 1;

    localparam logic [BW-1:0] BMAX = BW'(DIV - 1);
    localparam logic [OW-1:0] OMAX = OW'(OS_DIV - 1);

    logic [BW-1:0] bcnt;
    logic [OW-1:0] ocnt;
    logic          bwrap;
    logic          owrap;

    assign bwrap = (bcnt == BMAX);
    assign owrap = (ocnt == OMAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            bcnt      <= '0;
            baud_tick <= 1'b0;
        end else begin
            bcnt      <= bwrap ? '0 : bcnt + BW'(1);
            baud_tick <= bwrap;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ocnt    <= '0;
            os_tick <= 1'b0;
        end else begin
            ocnt    <= owrap ? '0 : ocnt + OW'(1);
            os_tick <= owrap;
        end
    end

endmodule

// File: tb/tb_baud_gen.sv
// Directed bench for baud_gen: default rates, a small override and a divide-by-1 case.
module tb_baud_gen;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic b0, o0, b1, o1, b2, o2;

    int errs   = 0;
    int checks = 0;
    int cnt_b0, cnt_o0, cnt_b1, cnt_o1, cnt_b2, cnt_o2;

    always #20 clk = ~clk;

    // Default: DIV=217, OS_DIV=14
    baud_gen u0 (.clk(clk), .rst(rst), .baud_tick(b0), .os_tick(o0));
    // 1 MHz / 100 kbaud / x4: DIV=10, OS_DIV=round(2.5)=3
    baud_gen #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .OVERSAMPLE(4))
        u1 (.clk(clk), .rst(rst), .baud_tick(b1), .os_tick(o1));
    // CLK_FREQ == BAUD_RATE: DIV=1, OS_DIV clamps to 1
    baud_gen #(.CLK_FREQ(115200), .BAUD_RATE(115200), .OVERSAMPLE(16))
        u2 (.clk(clk), .rst(rst), .baud_tick(b2), .os_tick(o2));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            if (errs <= 20)
                $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Edge n after reset release: a tick with divider d is high iff n is a multiple of d.
    task automatic run_cycles(input int ncyc);
        cnt_b0 = 0; cnt_o0 = 0; cnt_b1 = 0; cnt_o1 = 0; cnt_b2 = 0; cnt_o2 = 0;
        for (int n = 1; n <= ncyc; n++) begin
            @(posedge clk);
            @(negedge clk);
            chk("u0_baud", 32'(b0), 32'(n % 217 == 0));
            chk("u0_os",   32'(o0), 32'(n % 14 == 0));
            chk("u1_baud", 32'(b1), 32'(n % 10 == 0));
            chk("u1_os",   32'(o1), 32'(n % 3 == 0));
            chk("u2_baud", 32'(b2), 32'd1);
            chk("u2_os",   32'(o2), 32'd1);
            cnt_b0 += int'(b0 === 1'b1); cnt_o0 += int'(o0 === 1'b1);
            cnt_b1 += int'(b1 === 1'b1); cnt_o1 += int'(o1 === 1'b1);
            cnt_b2 += int'(b2 === 1'b1); cnt_o2 += int'(o2 === 1'b1);
        end
    endtask

    task automatic chk_all_low(input string tag);
        chk({tag, "_u0_baud"}, 32'(b0), 32'd0);
        chk({tag, "_u0_os"},   32'(o0), 32'd0);
        chk({tag, "_u1_baud"}, 32'(b1), 32'd0);
        chk({tag, "_u1_os"},   32'(o1), 32'd0);
        chk({tag, "_u2_baud"}, 32'(b2), 32'd0);
        chk({tag, "_u2_os"},   32'(o2), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk_all_low("reset");

        rst = 1'b0;
        run_cycles(50000);
        chk("u0_baud_count", 32'(cnt_b0), 32'd230);
        chk("u0_os_count",   32'(cnt_o0), 32'd3571);
        chk("u1_baud_count", 32'(cnt_b1), 32'd5000);
        chk("u1_os_count",   32'(cnt_o1), 32'd16666);
        chk("u2_baud_count", 32'(cnt_b2), 32'd50000);
        chk("u2_os_count",   32'(cnt_o2), 32'd50000);

        // Restart, count to 100, then pulse reset mid-count.
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        run_cycles(100);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk_all_low("midrst");
        rst = 1'b0;
        run_cycles(500);
        chk("post_rst_baud_count", 32'(cnt_b0), 32'd2);
        chk("post_rst_os_count",   32'(cnt_o0), 32'd35);
        chk("post_rst_u1_baud",    32'(cnt_b1), 32'd50);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/baud_gen.md
Name: baud_gen

Overview:
- Free-running clock divider that produces single-cycle UART bit-rate strobes from the system clock.
- Sits between the system clock and the UART TX/RX/detector FSMs.
- baud_tick marks one bit period; os_tick is an independent oversampling strobe for receiver mid-bit sampling.
- Purely synchronous, no handshake; outputs are enable strobes, never used as clocks.

Parameters:
- CLK_FREQ, 25_000_000, system clock frequency in Hz.
- BAUD_RATE, 115200, target bit rate in bits/s.
- OVERSAMPLE, 16, os_tick strobes per bit period.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- baud_tick  output  1  one-clk-wide pulse, once per bit period.
- os_tick  output  1  one-clk-wide pulse, OVERSAMPLE times per bit period (approximate).

Behaviour:
- Derived constants, computed at elaboration with rounded integer division:
  - DIV = (CLK_FREQ + BAUD_RATE/2) / BAUD_RATE.
  - OS_DIV = (CLK_FREQ + BAUD_RATE*OVERSAMPLE/2) / (BAUD_RATE*OVERSAMPLE).
  - Each constant is clamped to a minimum of 1.
  - Defaults: DIV = 217, OS_DIV = 14.
- Counter widths: $clog2(DIV) and $clog2(OS_DIV), minimum 1 bit each.
- Baud counter bcnt:
  - Reset value 0.
  - Each non-reset cycle: if bcnt == DIV-1 then bcnt <= 0, else bcnt <= bcnt+1.
- baud_tick:
  - Registered output, reset value 0.
  - Set to 1 in the cycle after the clock edge where bcnt == DIV-1; 0 otherwise.
  - Exactly one clk high, every DIV clocks.
  - First tick is high during cycle DIV after the first non-reset edge (edge DIV registers it).
- Oversample counter ocnt and os_tick:
  - Identical structure using OS_DIV.
  - Independent of bcnt; no phase alignment between os_tick and baud_tick is required.
  - Reset value of os_tick is 0.
- DIV == 1 (or OS_DIV == 1): the corresponding tick is held high every cycle after the first non-reset edge.
- Reset:
  - Asserting rst on any edge, including mid-count, clears both counters and both ticks on that edge.
  - Counting restarts from 0 on the first edge with rst low.
  - A tick in flight is dropped.
- No drift: the tick period is exactly DIV clocks indefinitely.
  - Default: 217 × 40 ns = 8680 ns, giving 115207 baud, +0.006% error.
- Outputs are never X after the first reset edge.

Test Plan:
- 25 MHz clk (40 ns period), rst high 200 ns then low -> baud_tick 0 during reset; first rise exactly 217 clks after reset release; each pulse exactly 40 ns wide.
- Run 2 ms after reset -> every baud_tick interval equals 8680 ns; count is 230 ± 1 pulses; no double or missing pulses.
- Same run -> os_tick interval always 14 clks (560 ns); ~15.5 os_ticks per baud_tick; pulse width 1 clk.
- Assert rst for 1 clk when bcnt ≈ 100 -> both ticks 0 next cycle; next baud_tick arrives 217 clks after rst deassert, not 117.
- Override CLK_FREQ = 1_000_000, BAUD_RATE = 100_000, OVERSAMPLE = 4 -> baud_tick every 10 clks; os_tick every 3 clks (OS_DIV = round(2.5) = 3).
- Override CLK_FREQ = BAUD_RATE -> baud_tick continuously high after the first non-reset edge.
